// File: rtl/contador_barrido.sv
// Scan generator for the 2-to-4 decoder: cycles Seleccion with a programmable
// dwell, optional blanking gap and single-step. Optional macro: BARRIDO_MASCARA_EN.
module contador_barrido #(
    parameter int unsigned ANCHO_PRESC        = 16,
    parameter int unsigned CUENTA_PERMANENCIA = 49999,
    parameter int unsigned CICLOS_BLANCO      = 4
) (
    input  logic       Reloj,
    input  logic       Reset_n,
    input  logic       Habilitar,
    input  logic       Paso,
`ifdef BARRIDO_MASCARA_EN
    input  logic [3:0] Mascara,
`endif
    output logic [1:0] Seleccion,
    output logic       Valida,
    output logic       FinBarrido
);

    typedef enum logic [1:0] {REPOSO, ACTIVO, BLANCO} estado_t;

    localparam logic [ANCHO_PRESC-1:0] FIN_PERM   = ANCHO_PRESC'(CUENTA_PERMANENCIA);
    localparam logic [ANCHO_PRESC-1:0] FIN_BLANCO =
        ANCHO_PRESC'((CICLOS_BLANCO > 0) ? CICLOS_BLANCO - 1 : 0);
    localparam bit HAY_BLANCO = (CICLOS_BLANCO > 0);

    estado_t                estado, estado_sig;
    logic [ANCHO_PRESC-1:0] cuenta, cuenta_sig;
    logic [1:0]             sel_sig, sel_nueva;
    logic                   valida_sig, fin_sig, avanzar, vuelta;

`ifdef BARRIDO_MASCARA_EN
    // Search upward from Seleccion+1; k=4 lands on Seleccion itself, so a
    // single enabled index holds and counts as a wrap. Empty mask: no move.
    logic [1:0] cand;
    logic       encontrado;
    always_comb begin
        sel_nueva  = Seleccion;
        encontrado = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = Seleccion + 2'(k);
            if (!encontrado && Mascara[cand]) begin
                sel_nueva  = cand;
                encontrado = 1'b1;
            end
        end
        vuelta = encontrado && (sel_nueva <= Seleccion);
    end
`else
    always_comb begin
        sel_nueva = Seleccion + 2'd1;
        vuelta    = (Seleccion == 2'd3);
    end
`endif

    always_comb begin
        estado_sig = estado;
        cuenta_sig = cuenta;
        valida_sig = 1'b0;
        avanzar    = 1'b0;
        unique case (estado)
            REPOSO: begin
                if (Habilitar) begin
                    estado_sig = ACTIVO;
                    cuenta_sig = '0;
                    valida_sig = 1'b1;
                end else if (Paso) begin
                    avanzar = 1'b1;
                end
            end
            ACTIVO: begin
                if (!Habilitar) begin
                    estado_sig = REPOSO;
                    cuenta_sig = '0;
                end else if (cuenta == FIN_PERM) begin
                    avanzar    = 1'b1;
                    cuenta_sig = '0;
                    if (HAY_BLANCO) begin
                        estado_sig = BLANCO;
                    end else begin
                        valida_sig = 1'b1;
                    end
                end else begin
                    cuenta_sig = cuenta + ANCHO_PRESC'(1);
                    valida_sig = 1'b1;
                end
            end
            BLANCO: begin
                if (!Habilitar) begin
                    estado_sig = REPOSO;
                    cuenta_sig = '0;
                end else if (cuenta == FIN_BLANCO) begin
                    estado_sig = ACTIVO;
                    cuenta_sig = '0;
                    valida_sig = 1'b1;
                end else begin
                    cuenta_sig = cuenta + ANCHO_PRESC'(1);
                end
            end
            default: begin
                estado_sig = REPOSO;
                cuenta_sig = '0;
            end
        endcase
        sel_sig = avanzar ? sel_nueva : Seleccion;
        fin_sig = avanzar && vuelta;
`ifdef BARRIDO_MASCARA_EN
        if (Mascara == 4'b0000) valida_sig = 1'b0;
`endif
    end

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado     <= REPOSO;
            cuenta     <= '0;
            Seleccion  <= '0;
            Valida     <= 1'b0;
            FinBarrido <= 1'b0;
        end else begin
            estado     <= estado_sig;
            cuenta     <= cuenta_sig;
            Seleccion  <= sel_sig;
            Valida     <= valida_sig;
            FinBarrido <= fin_sig;
        end
    end

endmodule

// File: tb/tb_contador_barrido.sv
// Directed bench for contador_barrido: dwell=4, blank=2 instance plus a
// no-blank instance; mask scenarios compile in with BARRIDO_MASCARA_EN.
module tb_contador_barrido;

    logic       reloj = 1'b0;
    logic       rst_n, hab, paso;
    logic       rst_n2, hab2;
    logic [1:0] sel, sel2;
    logic       valida, valida2, fin, fin2;
`ifdef BARRIDO_MASCARA_EN
    logic [3:0] mascara = 4'b1111;
`endif

    int checks = 0;
    int errors = 0;

    always #5 reloj = ~reloj;

    contador_barrido #(
        .ANCHO_PRESC(16), .CUENTA_PERMANENCIA(3), .CICLOS_BLANCO(2)
    ) dut (
        .Reloj(reloj), .Reset_n(rst_n), .Habilitar(hab), .Paso(paso),
`ifdef BARRIDO_MASCARA_EN
        .Mascara(mascara),
`endif
        .Seleccion(sel), .Valida(valida), .FinBarrido(fin)
    );

    contador_barrido #(
        .ANCHO_PRESC(16), .CUENTA_PERMANENCIA(3), .CICLOS_BLANCO(0)
    ) dut_sin_blanco (
        .Reloj(reloj), .Reset_n(rst_n2), .Habilitar(hab2), .Paso(1'b0),
`ifdef BARRIDO_MASCARA_EN
        .Mascara(4'b1111),
`endif
        .Seleccion(sel2), .Valida(valida2), .FinBarrido(fin2)
    );

    task automatic comprobar(input string tag, input int obs, input int esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Inputs are changed and outputs sampled 1 time unit after each rising edge.
    task automatic ciclo();
        @(posedge reloj);
        #1;
    endtask

    initial begin
        int fase, idx, hallado;
        rst_n = 1'b0; rst_n2 = 1'b0; hab = 1'b0; hab2 = 1'b0; paso = 1'b0;
        #2;
        comprobar("reset_sel", int'(sel), 0);
        comprobar("reset_valida", int'(valida), 0);
        comprobar("reset_fin", int'(fin), 0);
        ciclo();
        rst_n = 1'b1;
        hab   = 1'b1;

        // Normal scan: 4 valid, 2 blank; select moves on each Valida fall.
        for (int n = 1; n <= 60; n++) begin
            ciclo();
            fase = (n - 1) % 6;
            idx  = (n - 1) / 6;
            comprobar($sformatf("scan_valida_%0d", n), int'(valida), (fase < 4) ? 1 : 0);
            comprobar($sformatf("scan_sel_%0d", n), int'(sel), ((fase < 4) ? idx : idx + 1) % 4);
            comprobar($sformatf("scan_fin_%0d", n), int'(fin), (fase == 4 && idx % 4 == 3) ? 1 : 0);
        end

        // Now in the second blank cycle with Seleccion=2: stop.
        hab = 1'b0;
        ciclo();
        comprobar("stop_valida", int'(valida), 0);
        comprobar("stop_sel", int'(sel), 2);
        ciclo();
        comprobar("stop_hold_sel", int'(sel), 2);
        hab = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            ciclo();
            comprobar($sformatf("restart_valida_%0d", k), int'(valida), (k <= 4) ? 1 : 0);
            comprobar($sformatf("restart_sel_%0d", k), int'(sel), (k <= 4) ? 2 : 3);
        end

        // Single step from Seleccion=3.
        hab = 1'b0;
        ciclo();
        comprobar("idle_sel", int'(sel), 3);
        comprobar("idle_valida", int'(valida), 0);
        paso = 1'b1;
        ciclo();
        comprobar("step_wrap_sel", int'(sel), 0);
        comprobar("step_wrap_fin", int'(fin), 1);
        comprobar("step_wrap_valida", int'(valida), 0);
        paso = 1'b0;
        ciclo();
        comprobar("step_fin_clear", int'(fin), 0);
        comprobar("step_hold_sel", int'(sel), 0);
        paso = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            ciclo();
            comprobar($sformatf("step_multi_sel_%0d", k), int'(sel), k);
            comprobar($sformatf("step_multi_fin_%0d", k), int'(fin), 0);
        end
        hab = 1'b1;
        ciclo();
        paso = 1'b0;
        comprobar("hab_wins_sel", int'(sel), 3);
        comprobar("hab_wins_valida", int'(valida), 1);

        // Asynchronous reset while active on index 2.
        hallado = 0;
        for (int k = 0; k < 100 && hallado == 0; k++) begin
            ciclo();
            if (sel == 2'd2 && valida) hallado = 1;
        end
        comprobar("wait_sel2_active", hallado, 1);
        #2 rst_n = 1'b0;
        #1;
        comprobar("async_rst_sel", int'(sel), 0);
        comprobar("async_rst_valida", int'(valida), 0);
        comprobar("async_rst_fin", int'(fin), 0);
        hab = 1'b0;
        ciclo();
        rst_n = 1'b1;

        // No blanking: Valida stays high, select steps every 4 cycles.
        rst_n2 = 1'b1;
        hab2   = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            ciclo();
            comprobar($sformatf("noblank_valida_%0d", n), int'(valida2), 1);
            comprobar($sformatf("noblank_sel_%0d", n), int'(sel2), ((n - 1) / 4) % 4);
            comprobar($sformatf("noblank_fin_%0d", n), int'(fin2), (n == 17) ? 1 : 0);
        end
        hab2 = 1'b0;

`ifdef BARRIDO_MASCARA_EN
        // Mask 1010: sequence 0 (start), 1, 3, 1, 3 with wrap pulses on 3->1.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        mascara = 4'b1010;
        hab = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            ciclo();
            fase = (n - 1) % 6;
            idx  = (n - 1) / 6 + ((fase < 4) ? 0 : 1);
            comprobar($sformatf("mask_sel_%0d", n), int'(sel), (idx == 0) ? 0 : ((idx % 2 == 1) ? 1 : 3));
            comprobar($sformatf("mask_fin_%0d", n), int'(fin), (fase == 4 && idx >= 3 && idx % 2 == 1) ? 1 : 0);
        end
        mascara = 4'b0000;
        idx = int'(sel);
        for (int n = 1; n <= 12; n++) begin
            ciclo();
            comprobar($sformatf("mask0_valida_%0d", n), int'(valida), 0);
            comprobar($sformatf("mask0_sel_%0d", n), int'(sel), idx);
            comprobar($sformatf("mask0_fin_%0d", n), int'(fin), 0);
        end
        hab = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
